// File: rtl/mac_tx_wrap.sv
// AXI-Stream (64-bit) to Intel 10G MAC TX Avalon-ST bridge with runt padding, abort
// propagation, egress timestamping and TX statistics. Padding is built only with MAC_TX_PAD_EN.
module mac_tx_wrap #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  mac_clk,
  input  logic                  mac_rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] mac_tx_data,
  output logic [KEEP_WIDTH-1:0] mac_tx_valid_bytes,
  output logic                  mac_tx_sop,
  output logic                  mac_tx_eop,
  output logic                  mac_tx_error,
  output logic                  mac_tx_valid,
  input  logic                  mac_tx_ready,
  input  logic [63:0]           timestamp_cnt,
  output logic [63:0]           egress_ts,
  output logic                  egress_ts_valid,
  input  logic                  cfg_enable,
  output logic [31:0]           stat_tx_packets,
  output logic [31:0]           stat_tx_bytes,
  output logic [31:0]           stat_tx_aborts,
  output logic [31:0]           stat_tx_drops
);

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_DATA    = 2'd1,
`ifdef MAC_TX_PAD_EN
    TX_PAD     = 2'd2,
`endif
    TX_DISCARD = 2'd3
  } tx_state_e;

  localparam logic [KEEP_WIDTH-1:0] KEEP_FULL = '1;
  localparam logic [KEEP_WIDTH-1:0] KEEP_TAIL = KEEP_WIDTH'(4'hF);

  function automatic logic [15:0] keep_bytes(input logic [KEEP_WIDTH-1:0] k);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) n = n + 16'(k[i]);
    return n;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [KEEP_WIDTH-1:0] keep_q, keep_d;
  logic                  sop_q, sop_d, eop_q, eop_d, err_q, err_d, valid_q, valid_d;
  logic [2:0]            idx_q, idx_d;
  logic [15:0]           frame_bytes_q, frame_bytes_d;
  logic                  alive_q, alive_d;
  logic [63:0]           ts_q, ts_d;
  logic                  ts_valid_q, ts_valid_d;
  logic [31:0]           pkts_q, pkts_d, bytes_q, bytes_d, aborts_q, aborts_d, drops_q, drops_d;
`ifdef MAC_TX_PAD_EN
  logic                  abort_q, abort_d;
  logic                  need_pad;
  logic [DATA_WIDTH-1:0] data_masked;
`endif

  logic        load, tx_hs, eop_hs, first, in_pad, s_ready, acc, beat_ld, drop_inc;
  logic [2:0]  cur_idx;
  logic [15:0] base_bytes;

  // Handshake, framing and padding decisions for the single output stage.
  always_comb begin
    load       = ~valid_q | mac_tx_ready;
    tx_hs      = valid_q & mac_tx_ready;
    eop_hs     = tx_hs & eop_q;
    first      = (state_q == TX_IDLE);
    cur_idx    = first ? 3'd0 : idx_q;
    base_bytes = first ? 16'd0 : frame_bytes_q;
`ifdef MAC_TX_PAD_EN
    in_pad      = (state_q == TX_PAD);
    need_pad    = s_axis_tlast & (sat_add(base_bytes, keep_bytes(s_axis_tkeep)) < 16'd60);
    data_masked = '0;
    for (int i = 0; i < KEEP_WIDTH; i++)
      data_masked[i*8 +: 8] = s_axis_tkeep[i] ? s_axis_tdata[i*8 +: 8] : 8'h00;
    abort_d     = abort_q;
`else
    in_pad      = 1'b0;
`endif
    s_ready  = (state_q == TX_DISCARD) | (alive_q & load & ~in_pad);
    acc      = s_axis_tvalid & s_ready;

    state_d       = state_q;
    data_d        = data_q;
    keep_d        = keep_q;
    sop_d         = sop_q;
    eop_d         = eop_q;
    err_d         = err_q;
    valid_d       = valid_q;
    idx_d         = idx_q;
    frame_bytes_d = frame_bytes_q;
    beat_ld       = 1'b0;
    drop_inc      = 1'b0;
    alive_d       = 1'b1;

    if (load) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      err_d   = 1'b0;
      data_d  = '0;
      keep_d  = '0;
    end

    case (state_q)
      TX_IDLE, TX_DATA: begin
        if (acc) begin
          if (first && !cfg_enable) begin
            state_d  = s_axis_tlast ? TX_IDLE : TX_DISCARD;
            drop_inc = s_axis_tlast;
          end else begin
            beat_ld = 1'b1;
            valid_d = 1'b1;
            sop_d   = first;
            data_d  = s_axis_tdata;
            keep_d  = s_axis_tkeep;
            eop_d   = s_axis_tlast;
            err_d   = s_axis_tlast & s_axis_tuser;
            idx_d   = cur_idx + 3'd1;
            state_d = s_axis_tlast ? TX_IDLE : TX_DATA;
`ifdef MAC_TX_PAD_EN
            // A runt ending on beat 7 closes itself; earlier ones hand off to TX_PAD.
            if (need_pad) begin
              data_d = data_masked;
              if (cur_idx == 3'd7) begin
                keep_d = KEEP_TAIL;
              end else begin
                keep_d  = KEEP_FULL;
                eop_d   = 1'b0;
                err_d   = 1'b0;
                abort_d = s_axis_tuser;
                state_d = TX_PAD;
              end
            end
`endif
          end
        end
      end
`ifdef MAC_TX_PAD_EN
      TX_PAD: begin
        if (load) begin
          beat_ld = 1'b1;
          valid_d = 1'b1;
          data_d  = '0;
          keep_d  = (idx_q == 3'd7) ? KEEP_TAIL : KEEP_FULL;
          eop_d   = (idx_q == 3'd7);
          err_d   = (idx_q == 3'd7) & abort_q;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = TX_IDLE;
        end
      end
`endif
      TX_DISCARD: begin
        if (acc && s_axis_tlast) begin
          drop_inc = 1'b1;
          state_d  = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    if (beat_ld) frame_bytes_d = sat_add(sop_d ? 16'd0 : frame_bytes_q, keep_bytes(keep_d));

    // frame_bytes_q still holds the departing frame's total when its EOP handshakes.
    pkts_d     = pkts_q + 32'(eop_hs);
    bytes_d    = eop_hs ? bytes_q + {16'd0, frame_bytes_q} : bytes_q;
    aborts_d   = aborts_q + 32'(eop_hs & err_q);
    drops_d    = drops_q + 32'(drop_inc);
    ts_valid_d = tx_hs & sop_q;
    ts_d       = ts_valid_d ? timestamp_cnt : ts_q;
  end

  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      state_q       <= TX_IDLE;
      data_q        <= '0;
      keep_q        <= '0;
      sop_q         <= 1'b0;
      eop_q         <= 1'b0;
      err_q         <= 1'b0;
      valid_q       <= 1'b0;
      idx_q         <= '0;
      frame_bytes_q <= '0;
      alive_q       <= 1'b0;
      ts_q          <= '0;
      ts_valid_q    <= 1'b0;
      pkts_q        <= '0;
      bytes_q       <= '0;
      aborts_q      <= '0;
      drops_q       <= '0;
`ifdef MAC_TX_PAD_EN
      abort_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      keep_q        <= keep_d;
      sop_q         <= sop_d;
      eop_q         <= eop_d;
      err_q         <= err_d;
      valid_q       <= valid_d;
      idx_q         <= idx_d;
      frame_bytes_q <= frame_bytes_d;
      alive_q       <= alive_d;
      ts_q          <= ts_d;
      ts_valid_q    <= ts_valid_d;
      pkts_q        <= pkts_d;
      bytes_q       <= bytes_d;
      aborts_q      <= aborts_d;
      drops_q       <= drops_d;
`ifdef MAC_TX_PAD_EN
      abort_q       <= abort_d;
`endif
    end
  end

  assign s_axis_tready      = s_ready;
  assign mac_tx_data        = data_q;
  assign mac_tx_valid_bytes = keep_q;
  assign mac_tx_sop         = sop_q;
  assign mac_tx_eop         = eop_q;
  assign mac_tx_error       = err_q;
  assign mac_tx_valid       = valid_q;
  assign egress_ts          = ts_q;
  assign egress_ts_valid    = ts_valid_q;
  assign stat_tx_packets    = pkts_q;
  assign stat_tx_bytes      = bytes_q;
  assign stat_tx_aborts     = aborts_q;
  assign stat_tx_drops      = drops_q;

endmodule

// File: tb/tb_mac_tx_wrap.sv
// Self-checking bench for mac_tx_wrap: constant frame table, corner-case sequences and
// randomized frames scored against a byte-level frame model (padding follows MAC_TX_PAD_EN).
module tb_mac_tx_wrap;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        sop;
    logic        eop;
    logic        err;
  } beat_t;

  typedef struct {
    int len;
    bit abort;
    bit en;
    int exp_beats;
    int exp_bytes;
  } vec_t;

  logic        mac_clk = 1'b0;
  logic        mac_rst_n = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [63:0] mac_tx_data;
  logic [7:0]  mac_tx_valid_bytes;
  logic        mac_tx_sop, mac_tx_eop, mac_tx_error, mac_tx_valid;
  logic        mac_tx_ready = 1'b1;
  logic [63:0] timestamp_cnt = '0;
  logic [63:0] egress_ts;
  logic        egress_ts_valid;
  logic        cfg_enable = 1'b1;
  logic [31:0] stat_tx_packets, stat_tx_bytes, stat_tx_aborts, stat_tx_drops;

  int total = 0;
  int bad = 0;

  beat_t exp_q[$];
  int    obs_beats = 0;
  int    m_pkts = 0, m_bytes = 0, m_aborts = 0, m_drops = 0;
  int    rdy_mode = 0;
  bit    rdy_pat[$];

  mac_tx_wrap dut (
    .mac_clk            (mac_clk),
    .mac_rst_n          (mac_rst_n),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tkeep       (s_axis_tkeep),
    .s_axis_tlast       (s_axis_tlast),
    .s_axis_tuser       (s_axis_tuser),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .mac_tx_data        (mac_tx_data),
    .mac_tx_valid_bytes (mac_tx_valid_bytes),
    .mac_tx_sop         (mac_tx_sop),
    .mac_tx_eop         (mac_tx_eop),
    .mac_tx_error       (mac_tx_error),
    .mac_tx_valid       (mac_tx_valid),
    .mac_tx_ready       (mac_tx_ready),
    .timestamp_cnt      (timestamp_cnt),
    .egress_ts          (egress_ts),
    .egress_ts_valid    (egress_ts_valid),
    .cfg_enable         (cfg_enable),
    .stat_tx_packets    (stat_tx_packets),
    .stat_tx_bytes      (stat_tx_bytes),
    .stat_tx_aborts     (stat_tx_aborts),
    .stat_tx_drops      (stat_tx_drops)
  );

  initial forever #5 mac_clk = ~mac_clk;

  // Free-running timestamp with a random starting point.
  initial begin
    timestamp_cnt = {$urandom, $urandom};
    forever begin
      @(posedge mac_clk);
      #1 timestamp_cnt = timestamp_cnt + 64'd1;
    end
  end

  // MAC-side ready: always high, random, or a scripted pattern.
  initial forever begin
    @(posedge mac_clk);
    #1;
    if (rdy_mode == 1) mac_tx_ready = ($urandom_range(0, 3) != 0);
    else if (rdy_mode == 2 && rdy_pat.size() != 0) mac_tx_ready = rdy_pat.pop_front();
    else mac_tx_ready = 1'b1;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Output scoreboard, hold-under-backpressure check and egress timestamp check.
  logic [79:0] snap;
  logic [63:0] ts_exp, mask_m;
  bit          prev_stall = 0, ts_pend = 0;
  beat_t       bt_m;
  always @(negedge mac_clk) begin
    if (!mac_rst_n) begin
      prev_stall = 0;
      ts_pend    = 0;
    end else begin
      if (ts_pend || egress_ts_valid) begin
        checkOutput("egress_ts_valid", 80'(egress_ts_valid), 80'(ts_pend));
        if (ts_pend) checkOutput("egress_ts", 80'(egress_ts), 80'(ts_exp));
      end
      ts_pend = 0;
      if (prev_stall)
        checkOutput("hold", {4'h0, mac_tx_valid, mac_tx_sop, mac_tx_eop, mac_tx_error,
                             mac_tx_valid_bytes, mac_tx_data}, snap);
      if (mac_tx_valid && mac_tx_ready) begin
        obs_beats++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL beat: got unexpected beat data=%0h want none", mac_tx_data);
        end else begin
          bt_m = exp_q.pop_front();
          for (int j = 0; j < 8; j++) mask_m[j*8 +: 8] = {8{bt_m.keep[j]}};
          checkOutput("beat", {5'h0, mac_tx_sop, mac_tx_eop, mac_tx_error, mac_tx_valid_bytes,
                               mac_tx_data & mask_m},
                      {5'h0, bt_m.sop, bt_m.eop, bt_m.err, bt_m.keep, bt_m.data & mask_m});
        end
        if (mac_tx_sop) begin
          ts_pend = 1;
          ts_exp  = timestamp_cnt;
        end
      end
      prev_stall = mac_tx_valid && !mac_tx_ready;
      snap = {4'h0, mac_tx_valid, mac_tx_sop, mac_tx_eop, mac_tx_error, mac_tx_valid_bytes,
              mac_tx_data};
    end
  end

  // Builds the expected beats from the frame bytes, then drives the frame on s_axis.
  task automatic applyStimulus(input int len, input bit abort, input bit en, input bit wild,
                               input int rst_at);
    logic [7:0] fb[$];
    logic [7:0] ob[$];
    beat_t      bt;
    int         ol, nb, guard;
    bit         last;
    for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
    if (en) begin
      ob = fb;
`ifdef MAC_TX_PAD_EN
      while (ob.size() < 60) ob.push_back(8'h00);
`endif
      ol = ob.size();
      for (int b = 0; b * 8 < ol; b++) begin
        bt.data = '0;
        bt.keep = '0;
        for (int j = 0; j < 8; j++)
          if (b * 8 + j < ol) begin
            bt.data[j*8 +: 8] = ob[b*8+j];
            bt.keep[j] = 1'b1;
          end
        bt.sop = (b == 0);
        bt.eop = ((b + 1) * 8 >= ol);
        bt.err = bt.eop && abort;
        exp_q.push_back(bt);
      end
      m_pkts++;
      m_bytes += ol;
      if (abort) m_aborts++;
    end else begin
      m_drops++;
    end

    @(posedge mac_clk);
    #1;
    nb = (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      if (wild && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge mac_clk);
        #1;
      end
      last = (b == nb - 1);
      s_axis_tdata = {$urandom, $urandom};
      s_axis_tkeep = '0;
      for (int j = 0; j < 8; j++)
        if (b * 8 + j < len) begin
          s_axis_tdata[j*8 +: 8] = fb[b*8+j];
          s_axis_tkeep[j] = 1'b1;
        end
      s_axis_tlast  = last;
      s_axis_tuser  = last ? abort : (wild ? 1'($urandom_range(0, 1)) : 1'b0);
      cfg_enable    = (b == 0) ? en : (wild ? 1'($urandom_range(0, 1)) : 1'b1);
      s_axis_tvalid = 1'b1;
      if (b == rst_at) begin
        #1 mac_rst_n = 1'b0;
        return;
      end
      guard = 0;
      do begin
        @(negedge mac_clk);
        guard++;
      end while (!s_axis_tready && guard < 1000);
      if (!s_axis_tready) begin
        total++;
        bad++;
        $display("[TB] FAIL s_axis_tready: got 0 for 1000 cycles want 1");
      end
      @(posedge mac_clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    cfg_enable    = 1'b1;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge mac_clk);
      guard++;
    end
    checkOutput("drain_left", 80'(exp_q.size()), 80'd0);
    repeat (3) @(negedge mac_clk);
  endtask

  task automatic checkResetState();
    checkOutput("rst_valid", 80'(mac_tx_valid), 80'd0);
    checkOutput("rst_flags", {mac_tx_sop, mac_tx_eop, mac_tx_error}, 80'd0);
    checkOutput("rst_data", {mac_tx_valid_bytes, mac_tx_data}, 80'd0);
    checkOutput("rst_tready", 80'(s_axis_tready), 80'd0);
    checkOutput("rst_ts", {egress_ts_valid, egress_ts}, 80'd0);
    checkOutput("rst_pkts", 80'(stat_tx_packets), 80'd0);
    checkOutput("rst_bytes", 80'(stat_tx_bytes), 80'd0);
    checkOutput("rst_aborts", 80'(stat_tx_aborts), 80'd0);
    checkOutput("rst_drops", 80'(stat_tx_drops), 80'd0);
  endtask

  vec_t vecs[8];
  int   tbl_pkts = 0, tbl_bytes = 0, tbl_aborts = 0, tbl_drops = 0, zeros;

  initial begin
`ifdef MAC_TX_PAD_EN
    vecs = '{'{64, 0, 1, 8, 64}, '{11, 0, 1, 8, 60}, '{11, 1, 1, 8, 60}, '{20, 0, 0, 0, 0},
             '{60, 0, 1, 8, 60}, '{57, 1, 1, 8, 60}, '{8, 0, 1, 8, 60}, '{100, 0, 1, 13, 100}};
`else
    vecs = '{'{64, 0, 1, 8, 64}, '{11, 0, 1, 2, 11}, '{11, 1, 1, 2, 11}, '{20, 0, 0, 0, 0},
             '{60, 0, 1, 8, 60}, '{57, 1, 1, 8, 57}, '{8, 0, 1, 1, 8}, '{100, 0, 1, 13, 100}};
`endif
    #2 checkResetState();
    #21 mac_rst_n = 1'b1;

    // Frame table: beat count and cumulative statistics are constants from the table.
    for (int v = 0; v < 8; v++) begin
      obs_beats = 0;
      applyStimulus(vecs[v].len, vecs[v].abort, vecs[v].en, 0, -1);
      drain();
      tbl_pkts   += vecs[v].en ? 1 : 0;
      tbl_bytes  += vecs[v].exp_bytes;
      tbl_aborts += (vecs[v].en && vecs[v].abort) ? 1 : 0;
      tbl_drops  += vecs[v].en ? 0 : 1;
      checkOutput("tbl_beats", 80'(obs_beats), 80'(vecs[v].exp_beats));
      checkOutput("tbl_pkts", 80'(stat_tx_packets), 80'(tbl_pkts));
      checkOutput("tbl_bytes", 80'(stat_tx_bytes), 80'(tbl_bytes));
      checkOutput("tbl_aborts", 80'(stat_tx_aborts), 80'(tbl_aborts));
      checkOutput("tbl_drops", 80'(stat_tx_drops), 80'(tbl_drops));
    end

    // Input is held off while pad beats are generated.
    applyStimulus(11, 0, 1, 0, -1);
    zeros = 0;
    repeat (10) begin
      @(negedge mac_clk);
      if (!s_axis_tready) zeros++;
    end
`ifdef MAC_TX_PAD_EN
    checkOutput("pad_tready_low", 80'(zeros), 80'd6);
`else
    checkOutput("pad_tready_low", 80'(zeros), 80'd0);
`endif
    drain();

    // Scripted backpressure on a 20-byte frame.
    obs_beats = 0;
    rdy_pat = '{1, 1, 0, 0, 1, 0, 1};
    rdy_mode = 2;
    applyStimulus(20, 0, 1, 0, -1);
    drain();
    rdy_mode = 0;
`ifdef MAC_TX_PAD_EN
    checkOutput("bp_beats", 80'(obs_beats), 80'd8);
`else
    checkOutput("bp_beats", 80'(obs_beats), 80'd3);
`endif

    // Reset arrives while beat 3 of a 48-byte frame is presented.
    applyStimulus(48, 0, 1, 0, 3);
    #1 checkResetState();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    exp_q.delete();
    m_pkts = 0; m_bytes = 0; m_aborts = 0; m_drops = 0;
    repeat (2) @(negedge mac_clk);
    mac_rst_n = 1'b1;
    applyStimulus(64, 0, 1, 0, -1);
    drain();
    checkOutput("post_rst_pkts", 80'(stat_tx_packets), 80'd1);
    checkOutput("post_rst_bytes", 80'(stat_tx_bytes), 80'd64);

    // Random frames, gaps, mid-frame enable changes and random MAC backpressure.
    rdy_mode = 1;
    for (int n = 0; n < 40; n++)
      applyStimulus($urandom_range(1, 130), $urandom_range(0, 4) == 0,
                    $urandom_range(0, 6) != 0, 1, -1);
    drain();
    rdy_mode = 0;
    repeat (3) @(negedge mac_clk);
    checkOutput("rand_pkts", 80'(stat_tx_packets), 80'(m_pkts));
    checkOutput("rand_bytes", 80'(stat_tx_bytes), 80'(m_bytes));
    checkOutput("rand_aborts", 80'(stat_tx_aborts), 80'(m_aborts));
    checkOutput("rand_drops", 80'(stat_tx_drops), 80'(m_drops));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_tx_wrap.md
# mac_tx_wrap

Transmit-side counterpart of the 10G MAC receive wrapper. It accepts frames as 64-bit AXI-Stream in the `mac_clk` domain and drives the Intel 10G MAC IP TX Avalon-ST interface, generating SOP/EOP and valid-byte enables. It also pads runt frames to 60 bytes (pre-CRC), propagates abort as `mac_tx_error`, captures egress timestamps and keeps TX statistics. It sits between the core-to-MAC async FIFO output and the MAC IP.

## Interface
Parameters:
- `DATA_WIDTH`, 64: beat width. Only 64 is supported.
- `KEEP_WIDTH`, `DATA_WIDTH/8`: byte-enable width.

Ports:
- `mac_clk` in 1: 156.25 MHz. Single clock; all logic runs on it.
- `mac_rst_n` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in 64, `s_axis_tkeep` in 8, `s_axis_tlast` in 1: frame input. Byte 0 is in bits [7:0].
- `s_axis_tuser` in 1: abort flag, sampled on the tlast beat.
- `s_axis_tvalid` in 1, `s_axis_tready` out 1: input handshake.
- `mac_tx_data` out 64, `mac_tx_valid_bytes` out 8: data to the MAC IP.
- `mac_tx_sop` out 1, `mac_tx_eop` out 1, `mac_tx_error` out 1: frame framing and abort to the MAC IP.
- `mac_tx_valid` out 1, `mac_tx_ready` in 1: MAC IP handshake.
- `timestamp_cnt` in 64: free-running counter.
- `egress_ts` out 64, `egress_ts_valid` out 1: captured timestamp and its 1-cycle strobe.
- `cfg_enable` in 1: already synchronous to `mac_clk`.
- `stat_tx_packets`, `stat_tx_bytes`, `stat_tx_aborts`, `stat_tx_drops` out 32 each: statistics counters.

## Operation
- **Output stage:** one registered stage holds all `mac_tx_*` signals.
  - The stage loads when it is empty or when `mac_tx_valid && mac_tx_ready`.
  - Held data is stable while `mac_tx_ready` is low.
- **Input rules:**
  - tkeep is contiguous from the LSB and non-zero.
  - Non-last beats carry tkeep = 8'hFF.
- **State machine:**
  - **TX_IDLE:**
    - On the first accepted beat with `cfg_enable`=1, emit SOP.
    - If that beat is tlast, go to TX_IDLE or TX_PAD; otherwise go to TX_DATA.
    - On the first accepted beat with `cfg_enable`=0, go to TX_DISCARD. If the beat is also tlast, increment drops and stay in TX_IDLE.
  - **TX_DATA:**
    - Forward beats.
    - On tlast, go to TX_IDLE, or to TX_PAD if padding is needed.
  - **TX_PAD:**
    - `s_axis_tready`=0.
    - Emit zero beats until beat index 7.
    - Then go to TX_IDLE.
  - **TX_DISCARD:**
    - `s_axis_tready`=1 and nothing is emitted.
    - On tlast, increment `stat_tx_drops` and go to TX_IDLE.
- `cfg_enable` is sampled only at frame start. Deasserting it mid-frame lets the frame finish normally.
- **Byte count:** 16-bit, saturating at 16'hFFFF. It sums popcount(valid_bytes) of emitted beats, including pad and excluding CRC.
- **Padding** (applies when the tlast beat index k and count < 60):
  - **k<7:** the tlast beat goes out with keep 8'hFF, bytes beyond the original tkeep zeroed, and no EOP. TX_PAD then emits beats k+1..7.
  - **k=7:** keep is forced to 8'h0F, upper bytes are zeroed, and EOP is asserted.
  - A padded frame is always exactly 8 beats: beats 0–6 keep 8'hFF, beat 7 keep 8'h0F with EOP.
- **Abort:** `s_axis_tuser`=1 on tlast makes `mac_tx_error`=1 together with the frame's EOP beat (the pad beat if the frame is padded). `stat_tx_aborts` increments.
- **Statistics** (all wrap modulo 2^32):
  - `stat_tx_packets` increments at the EOP handshake of every frame, aborted ones included.
  - `stat_tx_bytes` adds the byte count at the EOP handshake.
- **Egress timestamp:** on an SOP handshake (`mac_tx_valid && mac_tx_ready && mac_tx_sop`), `egress_ts` = `timestamp_cnt` of that cycle. `egress_ts_valid` pulses on the next cycle.

## Timing
- **Latency:** an input beat handshake to `mac_tx_valid` takes 1 cycle.
- **Ready:** `s_axis_tready` = (stage empty or `mac_tx_ready`) and state ≠ TX_PAD. TX_DISCARD forces `s_axis_tready`=1.
- **Throughput:** full, one beat per cycle, with back-to-back frames. An SOP may load in the cycle after the previous EOP loads.
- **Pad beats:** one per cycle while `mac_tx_ready`=1.
- **Reset:** all outputs are 0, state is TX_IDLE, counters are 0, and the output stage is empty.
- **Reset mid-frame:** the frame is lost. No EOP is emitted, and the MAC IP sees `mac_tx_valid` drop to 0.
- **Simultaneous SOP handshake and stat update:** both take effect in the same cycle.

## Configuration
- `MAC_TX_PAD_EN` defined: padding logic and TX_PAD are present as described.
- `MAC_TX_PAD_EN` undefined:
  - TX_PAD and the padding logic are removed.
  - Runt frames pass unchanged, with the original tkeep and EOP on their own tlast beat.
  - The MAC IP pads them.
  - Byte counts reflect the unpadded length.

## Test plan
- **Single 64-byte frame:** 8 beats, last tkeep 8'hFF, tready always 1.
  - 8 beats out with SOP on beat 0 and EOP on beat 7.
  - packets=1, bytes=64.
  - `egress_ts_valid` pulses once with the timestamp of the SOP handshake cycle.
- **Runt frame (PAD_EN):** 2 beats, last tkeep 8'h07 (11 bytes).
  - Output is 8 beats: beat 1 keep 8'hFF with bytes 11–15 = 0, beats 2–6 all zero, beat 7 keep 8'h0F with EOP.
  - bytes=60.
- **Abort on runt:** same 11-byte frame with tuser=1 on tlast.
  - `mac_tx_error`=1 only on beat 7 with EOP.
  - aborts=1, packets=1.
- **Backpressure:** `mac_tx_ready` toggles 1,0,0,1 during a 3-beat 20-byte frame.
  - Data and flags hold while ready=0.
  - No beat lost or duplicated.
  - `s_axis_tready` is low during TX_PAD.
- **Disable at start:** `cfg_enable`=0 at SOP of a 3-beat frame, then 1.
  - No `mac_tx_valid`, drops=1.
  - The following frame is transmitted normally.
- **Reset mid-frame:** `mac_rst_n` asserted during beat 3.
  - All outputs and counters are 0.
  - The next frame starts with a clean SOP.
